universal_shift_register_burst: RTL and testbench

- Parametrised N-bit universal shift register with synchronous reset, clock enable and eight-entry mode select.
- Modes: hold, parallel load, logical shift, rotate and arithmetic shift.
- Adds a burst sequencer: one START command shifts the register CNT positions, one position per cycle, with a BUSY/DONE handshake.
- Used as the general serialiser/deserialiser and bit-manipulation register in datapaths that previously used fixed 8-bit shift registers.

---
 rtl/universal_shift_register_burst.sv | 142 ++++++++++++++
 tb/tb_universal_shift_register_burst.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register_burst.sv
// Universal N-bit shift register with hold/load/shift/rotate/arithmetic modes
// and a burst sequencer that shifts CNT positions, one per cycle, with a
// BUSY/DONE handshake. Outputs are taken directly from registered state.
module universal_shift_register_burst #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic [2:0]    MODE,
  input  logic [N-1:0]  DATA_IN,
  input  logic          Ileft,
  input  logic          Iright,
  input  logic          START,
  input  logic [CW-1:0] CNT,
  input  logic          DIR,
  output logic [N-1:0]  OUT,
  output logic          SO_LEFT,
  output logic          SO_RIGHT,
  output logic          BUSY,
  output logic          DONE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_LOAD  = 3'b001,
    M_SHL   = 3'b010,
    M_SHR   = 3'b011,
    M_ROL   = 3'b100,
    M_ROR   = 3'b101,
    M_ASR   = 3'b110,
    M_RSVD  = 3'b111
  } mode_t;

  localparam logic [CW-1:0] NMAX = CW'(N);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        r_state;
  logic [N-1:0]  r_out;
  logic [CW-1:0] r_cnt;
  logic          r_dir;
  logic          r_busy;
  logic          r_done;

  mode_t         w_mode;
  logic [N-1:0]  w_mode_out;
  logic [N-1:0]  w_burst_out;
  logic [CW-1:0] w_k;

  assign w_mode = mode_t'(MODE);

  // Saturate the requested burst length at the register width.
  assign w_k = (CNT > NMAX) ? NMAX : CNT;

  // Next register value for a single-cycle IDLE operation.
  always_comb begin
    w_mode_out = r_out;
    case (w_mode)
      M_HOLD: w_mode_out = r_out;
      M_LOAD: w_mode_out = DATA_IN;
      M_SHL:  w_mode_out = {r_out[N-2:0], Iright};
      M_SHR:  w_mode_out = {Ileft, r_out[N-1:1]};
      M_ROL:  w_mode_out = {r_out[N-2:0], r_out[N-1]};
      M_ROR:  w_mode_out = {r_out[0], r_out[N-1:1]};
      M_ASR:  w_mode_out = {r_out[N-1], r_out[N-1:1]};
      M_RSVD: w_mode_out = r_out;
      default: w_mode_out = r_out;
    endcase
  end

  // Next register value for one burst step in the latched direction.
  always_comb begin
    w_burst_out = r_out;
    if (r_dir) begin
      w_burst_out = {Ileft, r_out[N-1:1]};
    end else begin
      w_burst_out = {r_out[N-2:0], Iright};
    end
  end

  // Register, burst counter and sequencer; BUSY/DONE registered with the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out   <= '0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (EN) begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_dir <= DIR;
            if (w_k == '0) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_cnt   <= w_k;
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
            end
          end else begin
            r_out <= w_mode_out;
          end
        end
        S_SHIFT: begin
          r_out <= w_burst_out;
          r_cnt <= r_cnt - ONE;
          if (r_cnt == ONE) begin
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign OUT      = r_out;
  assign SO_LEFT  = r_out[N-1];
  assign SO_RIGHT = r_out[0];
  assign BUSY     = r_busy;
  assign DONE     = r_done;

endmodule

// File: tb/tb_universal_shift_register_burst.sv
// Directed plus randomized bench for universal_shift_register_burst (N=8).
module tb_universal_shift_register_burst;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EN = 1'b0;
  logic [2:0]    MODE = 3'b000;
  logic [N-1:0]  DATA_IN = '0;
  logic          Ileft = 1'b0;
  logic          Iright = 1'b0;
  logic          START = 1'b0;
  logic [CW-1:0] CNT = '0;
  logic          DIR = 1'b0;
  logic [N-1:0]  OUT;
  logic          SO_LEFT;
  logic          SO_RIGHT;
  logic          BUSY;
  logic          DONE;

  int n_total = 0;
  int n_pass  = 0;

  universal_shift_register_burst #(.N(N), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .DATA_IN(DATA_IN),
    .Ileft(Ileft), .Iright(Iright), .START(START), .CNT(CNT), .DIR(DIR),
    .OUT(OUT), .SO_LEFT(SO_LEFT), .SO_RIGHT(SO_RIGHT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference: one IDLE operation on an 8-bit value, in plain arithmetic.
  function automatic int ref_op(input int m, input int mode, input int d,
                                input int il, input int ir);
    case (mode)
      1: return d & 255;
      2: return ((m * 2) + ir) % 256;
      3: return (m / 2) + il * 128;
      4: return ((m * 2) % 256) + (m / 128);
      5: return (m / 2) + (m % 2) * 128;
      6: return (m / 2) + (m / 128) * 128;
      default: return m;
    endcase
  endfunction

  task automatic chk_out(input string tag, input int m);
    chk(tag, 32'(OUT), 32'(m));
    chk({tag, "_sol"}, 32'(SO_LEFT), 32'(m / 128));
    chk({tag, "_sor"}, 32'(SO_RIGHT), 32'(m % 2));
  endtask

  initial begin
    int m;
    int busy_cnt;
    int done_cnt;
    int k;
    int rem;
    int guard;
    logic [7:0] sweep_mode [6];
    logic [7:0] sweep_exp  [6];

    // Reset for two cycles.
    RST = 1'b1; EN = 1'b1;
    step(); step();
    chk("rst_out", 32'(OUT), 32'h00);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);

    // Load.
    RST = 1'b0; MODE = 3'b001; DATA_IN = 8'hB4;
    step();
    chk_out("load", 8'hB4);

    // Mode sweep, reloading 0xB4 between ops.
    sweep_mode = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    sweep_exp  = '{8'h69, 8'h5A, 8'h69, 8'h5A, 8'hDA, 8'hB4};
    Iright = 1'b1; Ileft = 1'b0;
    for (int i = 0; i < 6; i++) begin
      MODE = 3'b001; DATA_IN = 8'hB4; step();
      MODE = sweep_mode[i][2:0]; step();
      chk($sformatf("sweep_m%0d", sweep_mode[i]), 32'(OUT), 32'(sweep_exp[i]));
    end

    // Burst: 0x81, CNT=3, DIR=1, Ileft=1, MODE=010 during the burst.
    MODE = 3'b001; DATA_IN = 8'h81; step();
    MODE = 3'b000; START = 1'b1; CNT = 4'd3; DIR = 1'b1; Ileft = 1'b1;
    step();
    chk("b3_start_busy", 32'(BUSY), 32'd1);
    chk("b3_start_out", 32'(OUT), 32'h81);
    START = 1'b0; MODE = 3'b010;
    step(); chk("b3_s1", 32'(OUT), 32'hC0); chk("b3_s1_busy", 32'(BUSY), 32'd1);
    step(); chk("b3_s2", 32'(OUT), 32'hE0); chk("b3_s2_busy", 32'(BUSY), 32'd1);
    step(); chk("b3_s3", 32'(OUT), 32'hF0);
    chk("b3_busy_end", 32'(BUSY), 32'd0);
    chk("b3_done", 32'(DONE), 32'd1);
    step();
    chk("b3_done_fall", 32'(DONE), 32'd0);
    chk("b3_fin_out", 32'(OUT), 32'hF0);
    MODE = 3'b000;

    // CNT=0: no BUSY, DONE next cycle, OUT unchanged.
    START = 1'b1; CNT = 4'd0; step(); START = 1'b0;
    chk("c0_busy", 32'(BUSY), 32'd0);
    chk("c0_done", 32'(DONE), 32'd1);
    chk("c0_out", 32'(OUT), 32'hF0);
    step();
    chk("c0_done_fall", 32'(DONE), 32'd0);

    // CNT=15 saturates to 8 shifts.
    MODE = 3'b001; DATA_IN = 8'hFF; step(); MODE = 3'b000;
    START = 1'b1; CNT = 4'd15; DIR = 1'b0; Iright = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    step(); START = 1'b0;
    guard = 0;
    while (DONE !== 1'b1 && guard < 30) begin
      if (BUSY === 1'b1) busy_cnt++;
      step(); guard++;
    end
    chk("sat_timeout", 32'(guard < 30), 32'd1);
    chk("sat_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("sat_out", 32'(OUT), 32'h00);
    step();

    // EN stall mid-burst.
    MODE = 3'b001; DATA_IN = 8'h01; step(); MODE = 3'b000;
    START = 1'b1; CNT = 4'd4; DIR = 1'b0; Iright = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    step(); START = 1'b0; busy_cnt += int'(BUSY);
    step(); busy_cnt += int'(BUSY); chk("stall_s1", 32'(OUT), 32'h02);
    EN = 1'b0;
    step(); busy_cnt += int'(BUSY); chk("stall_h1", 32'(OUT), 32'h02);
    step(); busy_cnt += int'(BUSY); chk("stall_h2", 32'(OUT), 32'h02);
    EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); busy_cnt += int'(BUSY); done_cnt += int'(DONE);
    end
    step(); done_cnt += int'(DONE);
    chk("stall_busy_cycles", 32'(busy_cnt), 32'd6);
    chk("stall_out", 32'(OUT), 32'h10);
    chk("stall_done_pulses", 32'(done_cnt), 32'd1);

    // Reset mid-burst, then immediate new START.
    START = 1'b1; CNT = 4'd6; step(); START = 1'b0;
    step(); step();
    chk("rmb_busy3", 32'(BUSY), 32'd1);
    RST = 1'b1; step(); RST = 1'b0;
    chk("rmb_out", 32'(OUT), 32'h00);
    chk("rmb_busy", 32'(BUSY), 32'd0);
    chk("rmb_done", 32'(DONE), 32'd0);
    START = 1'b1; CNT = 4'd2; DIR = 1'b0; Iright = 1'b1; step(); START = 1'b0;
    chk("rmb_restart", 32'(BUSY), 32'd1);
    step(); step();
    chk("rmb_restart_done", 32'(DONE), 32'd1);
    chk("rmb_restart_out", 32'(OUT), 32'h03);
    step();

    // Randomized ops and bursts against the reference model.
    m = 3;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        MODE = 3'($urandom_range(0, 7));
        DATA_IN = 8'($urandom);
        Ileft = 1'($urandom); Iright = 1'($urandom);
        EN = ($urandom_range(0, 4) != 0);
        step();
        if (EN) m = ref_op(m, int'(MODE), int'(DATA_IN), int'(Ileft), int'(Iright));
        chk_out("rnd_op", m);
        chk("rnd_op_busy", 32'(BUSY), 32'd0);
        chk("rnd_op_done", 32'(DONE), 32'd0);
      end else begin
        EN = 1'b1;
        START = 1'b1;
        CNT = 4'($urandom_range(0, 15));
        DIR = 1'($urandom);
        MODE = 3'($urandom_range(0, 7));
        k = (int'(CNT) > N) ? N : int'(CNT);
        step();
        chk("rnd_b_start_out", 32'(OUT), 32'(m));
        chk("rnd_b_start_busy", 32'(BUSY), 32'(k > 0));
        chk("rnd_b_start_done", 32'(DONE), 32'(k == 0));
        rem = k;
        guard = 0;
        while (rem > 0 && guard < 100) begin
          EN = ($urandom_range(0, 3) != 0);
          START = 1'($urandom);
          MODE = 3'($urandom_range(0, 7));
          Ileft = 1'($urandom); Iright = 1'($urandom);
          step();
          if (EN) begin
            m = DIR ? ref_op(m, 3, 0, int'(Ileft), 0) : ref_op(m, 2, 0, 0, int'(Iright));
            rem--;
          end
          guard++;
          chk_out("rnd_b_shift", m);
          chk("rnd_b_busy", 32'(BUSY), 32'(rem > 0));
          chk("rnd_b_done", 32'(DONE), 32'(rem == 0));
        end
        chk("rnd_b_timeout", 32'(guard < 100), 32'd1);
        EN = 1'b1;
        START = 1'($urandom);
        MODE = 3'($urandom_range(0, 7));
        step();
        START = 1'b0;
        chk("rnd_b_fin_out", 32'(OUT), 32'(m));
        chk("rnd_b_fin_busy", 32'(BUSY), 32'd0);
        chk("rnd_b_fin_done", 32'(DONE), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
